// File: rtl/lht_rollback_controller.sv
// Speculative-update sequencer for the local history table: checkpoints pre-shift
// histories in an in-order queue and replays them youngest-first on a mispredict.
module lht_rollback_controller #(
    parameter int INDEX_LEN   = 7,
    parameter int HISTORY_LEN = 10,
    parameter int DEPTH       = 8,
    parameter int PTR_LEN     = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   pred_valid_i,
    input  logic [INDEX_LEN-1:0]   pred_pc_bits_i,
    input  logic [HISTORY_LEN-1:0] pred_history_i,
    output logic                   pred_ready_o,
    output logic                   predict_enable_o,
    input  logic                   resolve_valid_i,
    input  logic                   resolve_taken_i,
    input  logic                   resolve_pred_i,
    output logic                   resolve_ready_o,
    output logic                   rollback_enabled_o,
    output logic [INDEX_LEN-1:0]   pc_bits_write_o,
    output logic [HISTORY_LEN-1:0] history_write_o,
    output logic                   busy_o,
    output logic [PTR_LEN:0]       count_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ROLLBACK = 2'd1, REPAIR = 2'd2} state_t;

    localparam logic [PTR_LEN:0]   DEPTH_CNT = (PTR_LEN+1)'(DEPTH);
    localparam logic [PTR_LEN:0]   ONE_CNT   = (PTR_LEN+1)'(1);
    localparam logic [PTR_LEN-1:0] ONE_PTR   = PTR_LEN'(1);

    logic [INDEX_LEN-1:0]   mem_pc_q   [DEPTH];
    logic [HISTORY_LEN-1:0] mem_hist_q [DEPTH];

    state_t                 state_q, state_d;
    logic [PTR_LEN-1:0]     head_q, head_d, tail_q, tail_d, rb_idx_s;
    logic [PTR_LEN:0]       count_q, count_d;
    logic [INDEX_LEN-1:0]   fix_pc_q, fix_pc_d, pc_wr_q, pc_wr_d;
    logic [HISTORY_LEN-1:0] fix_hist_q, fix_hist_d, hist_wr_q, hist_wr_d;
    logic                   fix_dir_q, fix_dir_d, rb_en_q, rb_en_d;
    logic                   pred_ready_q, pred_ready_d, resolve_ready_q, resolve_ready_d;
    logic                   busy_q, busy_d;
    logic                   push_s, pop_s, mispred_s;

    assign push_s           = pred_valid_i & pred_ready_q;
    assign pop_s            = resolve_valid_i & resolve_ready_q;
    assign mispred_s        = pop_s & (resolve_taken_i != resolve_pred_i);
    assign predict_enable_o = push_s;

    assign pred_ready_o       = pred_ready_q;
    assign resolve_ready_o    = resolve_ready_q;
    assign rollback_enabled_o = rb_en_q;
    assign pc_bits_write_o    = pc_wr_q;
    assign history_write_o    = hist_wr_q;
    assign busy_o             = busy_q;
    assign count_o            = count_q;

    // Next-state, pointer and registered-output computation
    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        fix_pc_d   = fix_pc_q;
        fix_hist_d = fix_hist_q;
        fix_dir_d  = fix_dir_q;
        rb_en_d    = 1'b0;
        pc_wr_d    = '0;
        hist_wr_d  = '0;
        rb_idx_s   = '0;
        case (state_q)
            IDLE: begin
                if (push_s) tail_d = tail_q + ONE_PTR;
                else        tail_d = tail_q;
                if (pop_s)  head_d = head_q + ONE_PTR;
                else        head_d = head_q;
                if (push_s && !pop_s)      count_d = count_q + ONE_CNT;
                else if (!push_s && pop_s) count_d = count_q - ONE_CNT;
                else                       count_d = count_q;
                if (mispred_s) begin
                    fix_pc_d   = mem_pc_q[head_q];
                    fix_hist_d = mem_hist_q[head_q];
                    fix_dir_d  = resolve_taken_i;
                    state_d    = (count_d != '0) ? ROLLBACK : REPAIR;
                end else begin
                    state_d = IDLE;
                end
            end
            ROLLBACK: begin
                tail_d  = tail_q - ONE_PTR;
                count_d = count_q - ONE_CNT;
                state_d = (count_d == '0) ? REPAIR : ROLLBACK;
            end
            REPAIR:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A push accepted alongside the mispredict is the youngest entry and is not yet in memory
        case (state_d)
            ROLLBACK: begin
                rb_en_d  = 1'b1;
                rb_idx_s = tail_d - ONE_PTR;
                if (state_q == IDLE && push_s) begin
                    pc_wr_d   = pred_pc_bits_i;
                    hist_wr_d = pred_history_i;
                end else begin
                    pc_wr_d   = mem_pc_q[rb_idx_s];
                    hist_wr_d = mem_hist_q[rb_idx_s];
                end
            end
            REPAIR: begin
                rb_en_d   = 1'b1;
                pc_wr_d   = fix_pc_d;
                hist_wr_d = {fix_hist_d[HISTORY_LEN-2:0], fix_dir_d};
            end
            default: rb_en_d = 1'b0;
        endcase

        pred_ready_d    = (state_d == IDLE) && (count_d < DEPTH_CNT);
        resolve_ready_d = (state_d == IDLE) && (count_d != '0);
        busy_d          = (state_d != IDLE);
    end

    // FSM, pointers and registered outputs
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q         <= IDLE;
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            fix_pc_q        <= '0;
            fix_hist_q      <= '0;
            fix_dir_q       <= 1'b0;
            rb_en_q         <= 1'b0;
            pc_wr_q         <= '0;
            hist_wr_q       <= '0;
            pred_ready_q    <= 1'b1;
            resolve_ready_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            fix_pc_q        <= fix_pc_d;
            fix_hist_q      <= fix_hist_d;
            fix_dir_q       <= fix_dir_d;
            rb_en_q         <= rb_en_d;
            pc_wr_q         <= pc_wr_d;
            hist_wr_q       <= hist_wr_d;
            pred_ready_q    <= pred_ready_d;
            resolve_ready_q <= resolve_ready_d;
            busy_q          <= busy_d;
        end
    end

    // Checkpoint storage written at the tail on every accepted prediction
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_pc_q[tail_q]   <= pred_pc_bits_i;
            mem_hist_q[tail_q] <= pred_history_i;
        end
    end

endmodule

// File: doc/lht_rollback_controller.md
Name: lht_rollback_controller

Overview:
- Sequences speculative updates and mispredict recovery for the local history table (LHT).
- Gates each prediction-time shift and checkpoints the pre-shift history of every in-flight branch in an in-order queue.
- Retires the oldest entry on a correct resolution.
- On a mispredict, drives the LHT parallel-load port to restore younger entries youngest-first, then writes the corrected history for the mispredicted branch.

Parameters:
INDEX_LEN, 7, LHT index width (pc bits)
HISTORY_LEN, 10, history register width
DEPTH, 8, checkpoint queue entries; power of two, >= 2
PTR_LEN, 3, log2(DEPTH)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
pred_valid  in  1  front end requests a prediction this cycle
pred_pc_bits  in  INDEX_LEN  LHT index being predicted (same value driven to LHT pc_bits_read)
pred_history  in  HISTORY_LEN  LHT history_read for that index (pre-shift value)
pred_ready  out  1  prediction can be accepted
predict_enable  out  1  to LHT predict_enable; = pred_valid & pred_ready
resolve_valid  in  1  oldest in-flight branch resolved this cycle
resolve_taken  in  1  actual direction of that branch
resolve_pred  in  1  direction that was predicted for it
resolve_ready  out  1  resolution can be accepted
rollback_enabled  out  1  to LHT rollback_enabled (parallel-load strobe)
pc_bits_write  out  INDEX_LEN  to LHT pc_bits_write
history_write  out  HISTORY_LEN  to LHT history_write
busy  out  1  recovery in progress
count  out  PTR_LEN+1  occupied queue entries

Behaviour:
- Queue storage: each entry holds {pc_bits, pre-shift history}. Head = oldest entry, tail = next write slot; pointers wrap modulo DEPTH.
- Reset (reset=0, asynchronous): head=tail=0, count=0, state=IDLE.
  - Output values in reset: rollback_enabled=0, pc_bits_write=0, history_write=0, busy=0, pred_ready=1, resolve_ready=0.
- Handshake rules:
  - pred_ready = (state==IDLE) & (count<DEPTH).
  - resolve_ready = (state==IDLE) & (count!=0).
  - A transfer occurs only when valid & ready are both high. With ready low, valid is ignored and nothing is latched.
- Accepted prediction: push {pred_pc_bits, pred_history} at the tail; tail++; count++. The LHT shifts the same cycle via predict_enable.
- Accepted resolution with resolve_taken==resolve_pred (correct): pop head; head++; count--. Stays IDLE.
- Simultaneous correct resolve and prediction in IDLE: both occur; count is unchanged; a push into a full queue is still blocked by pred_ready.
- Accepted resolution with a mismatch (mispredict):
  - Latch the head entry into fix_pc/fix_hist and the bit fix_dir=resolve_taken.
  - Pop the head.
  - A prediction offered the same cycle is still accepted (pred_ready is high), pushed, and restored during recovery.
  - Next state: ROLLBACK if the remaining count is nonzero, else REPAIR.
- ROLLBACK, one entry per cycle, youngest first:
  - Drive rollback_enabled=1, pc_bits_write/history_write = entry[tail-1].
  - Then tail--, count--.
  - When count reaches 0 → REPAIR.
  - Youngest-first order gives the correct result when several in-flight entries share an index.
- REPAIR, one cycle:
  - rollback_enabled=1, pc_bits_write=fix_pc, history_write={fix_hist[HISTORY_LEN-2:0], fix_dir} (LHT shift convention: new bit enters bit 0).
  - Then → IDLE.
- Recovery latency: with N younger entries, exactly N+1 cycles of rollback_enabled, starting the cycle after the mispredict. Queue is empty on return to IDLE.
- busy=1 in ROLLBACK and REPAIR. pred_ready=resolve_ready=0 while busy, so predict_enable never overlaps rollback_enabled.
- Outside ROLLBACK/REPAIR: rollback_enabled=0, pc_bits_write/history_write=0.
- Reset asserted mid-recovery: immediate return to the reset state; the partial restore is abandoned.
- Outputs are registered or state-decoded only; predict_enable is the single combinational valid&ready path.

Test Plan:
- Reset then idle: pred_ready=1, resolve_ready=0, count=0, rollback_enabled=0 for 10 cycles; resolve_valid=1 when empty → no state change.
- Push 8 predictions (pc 0..7) → count=8, pred_ready=0; 9th pred_valid gives predict_enable=0; one correct resolve → count=7, pred_ready=1.
- Push pc=5 hist=0x2A5, then resolve taken=1 pred=0 → next cycle a single REPAIR: rollback_enabled=1, pc_bits_write=5, history_write=0x14B; then IDLE, count=0.
- Push A(pc 3, hist 0x001), B(pc 3, hist 0x003), C(pc 9, hist 0x100); mispredict A with taken=0 → writes pc9←0x100, pc3←0x003, pc3←0x002 on three consecutive cycles, busy=1 throughout.
- Correct resolve and prediction in the same cycle at count=4 → count stays 4, head and tail both advance; repeat across pointer wrap (≥12 iterations) with no corruption.
- Assert reset during ROLLBACK with 3 entries left → rollback_enabled=0 immediately, count=0, busy=0, pred_ready=1 after release.
